// File: rtl/btn_conditioner.sv
// Push-button front end: two-flop synchroniser, per-bit debounce with rising-edge
// pulse, and an arbiter that folds the four direction buttons into a one-hot vector.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn_raw,
  output logic [4:0] btn_level,
  output logic [4:0] btn_press,
  output logic [4:0] btn_out,
  output logic       dir_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  logic [4:0]       sync_q1;
  logic [4:0]       sync_q2;
  logic [4:0]       stable_q;
  logic [4:0]       stable_d;
  logic [4:0]       press_q;
  logic [CNT_W-1:0] cnt_q [5];
  logic [CNT_W-1:0] cnt_d [5];

  state_t           state_q;
  state_t           state_d;
  logic [3:0]       sel_q;
  logic [3:0]       sel_d;
  logic [3:0]       dir_lvl;
  logic [3:0]       dir_onehot;

  // v & -v isolates the lowest set bit, giving up > left > right > down priority.
  function automatic logic [3:0] lowest_set(input logic [3:0] v);
    return v & (~v + 4'd1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  // A disagreeing sample counts up; any agreeing sample restarts the run.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = '0;
      if (sync_q2[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_q <= '0;
      press_q  <= '0;
      for (int i = 0; i < 5; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      press_q  <= stable_d & ~stable_q;
      for (int i = 0; i < 5; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign dir_lvl = stable_q[4:1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // The held direction keeps ownership; on its release the lowest other held one takes over.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    if (state_q == ST_IDLE) begin
      if (|dir_lvl) begin
        state_d = ST_HOLD;
        sel_d   = lowest_set(dir_lvl);
      end
    end else begin
      if (!(|(dir_lvl & sel_q))) begin
        if (|dir_lvl) begin
          sel_d = lowest_set(dir_lvl);
        end else begin
          state_d = ST_IDLE;
          sel_d   = '0;
        end
      end
    end
  end

  assign dir_onehot = (state_q == ST_HOLD) ? sel_q : 4'd0;
  assign btn_level  = stable_q;
  assign btn_press  = press_q;
  assign btn_out    = {dir_onehot, stable_q[0]};
  assign dir_valid  = |dir_onehot;

endmodule
